// File: rtl/mac_pkg.sv
// Shared definitions for the MAC row controller: FSM state encoding and the
// two-bit instruction codes driven onto a MAC row.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // inst_w encoding: bit1 = execute, bit0 = kernel load
    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_row_ctrl.sv
// Sequences one MAC row through kernel load, pipeline gap, execute and drain.
// Optional MAC_ROW_CTRL_PERF_EN adds a 16-bit busy-cycle counter output.
module mac_row_ctrl
    import mac_pkg::*;
#(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [len_bw-1:0] exec_len,
    input  logic              cfg_mode,
    input  logic [bw-1:0]     data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [bw-1:0]     in_w,
    output logic [1:0]        inst_w,
    output logic              mode,
    input  logic [col-1:0]    row_valid,
    output logic              busy,
    output logic              done,
    output logic [len_bw-1:0] out_cnt
`ifdef MAC_ROW_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    // One phase counter serves LOAD, GAP and EXEC, so it must hold both ranges.
    localparam int COL_W = $clog2(col + 1);
    localparam int CNT_W = (len_bw > COL_W) ? len_bw : COL_W;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(col - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [len_bw-1:0] exec_len_q;
    logic              accept;
    logic              xfer;
    logic              last_col;
    logic              last_exec;
    logic              cnt_adv;

    assign accept    = (state == ST_IDLE) && start;
    assign xfer      = data_valid && data_ready;
    assign last_col  = (cnt == LAST_COL);
    assign last_exec = ((cnt + CNT_W'(1)) == CNT_W'(exec_len_q));
    assign cnt_adv   = (state == ST_GAP) || xfer;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register updates from the same pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start)             state_next = ST_LOAD;
            ST_LOAD:  if (xfer && last_col)  state_next = ST_GAP;
            ST_GAP:   if (last_col)          state_next = (exec_len_q == '0) ? ST_DONE : ST_EXEC;
            ST_EXEC:  if (xfer && last_exec) state_next = ST_DRAIN;
            ST_DRAIN: if (out_cnt == exec_len_q) state_next = ST_DONE;
            ST_DONE:                         state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        data_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            ST_IDLE:  busy       = 1'b0;
            ST_LOAD:  data_ready = 1'b1;
            ST_EXEC:  data_ready = 1'b1;
            ST_DONE:  done       = 1'b1;
            default:  ;
        endcase
    end

    // Row drive lags each transfer by one cycle; idle cycles become NOP bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            exec_len_q <= '0;
            mode       <= 1'b0;
            in_w       <= '0;
            inst_w     <= INST_NOP;
            out_cnt    <= '0;
        end else begin
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt_adv) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                exec_len_q <= exec_len;
                mode       <= cfg_mode;
            end

            inst_w <= INST_NOP;
            if (xfer) begin
                in_w   <= data_in;
                inst_w <= (state == ST_LOAD) ? INST_LOAD : INST_EXEC;
            end

            if (accept) begin
                out_cnt <= '0;
            end else if (busy && row_valid[col-1] && (out_cnt != '1)) begin
                out_cnt <= out_cnt + len_bw'(1);
            end
        end
    end

`ifdef MAC_ROW_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 16'hFFFF)) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mac_row_ctrl.md
MAC_ROW_CTRL -- requirements
Module: mac_row_ctrl

Interface
REQ-001 SHALL have parameter bw, default 4, meaning the in_w data width.
REQ-002 SHALL have parameter col, default 8, meaning the number of MAC tiles in the driven row.
REQ-003 SHALL have parameter len_bw, default 8, meaning the width of the exec length and output counters.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to run a job.
REQ-007 SHALL have port exec_len, input, len_bw bits: number of activations, sampled on an accepted start.
REQ-008 SHALL have port cfg_mode, input, 1 bit: row mode, sampled on an accepted start.
REQ-009 SHALL have ports data_in (input, bw bits), data_valid (input, 1 bit) and data_ready (output, 1 bit): the weight/activation stream.
REQ-010 SHALL have ports in_w (output, bw bits), inst_w (output, 2 bits; bit1 = execute, bit0 = kernel load) and mode (output, 1 bit): the row drive.
REQ-011 SHALL have port row_valid, input, col bits: per-column valid from the row.
REQ-012 SHALL have ports busy (output, 1 bit), done (output, 1 bit pulse) and out_cnt (output, len_bw bits).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
REQ-014 SHALL accept start only in IDLE; start in any other state is ignored. Acceptance latches exec_len and cfg_mode, clears out_cnt, and moves to LOAD.
REQ-015 SHALL drive data_ready=1 only in LOAD and EXEC.
REQ-016 SHALL transfer a word only on data_valid&&data_ready.
REQ-017 SHALL, in LOAD, register the word onto in_w with inst_w=01 one cycle after each transfer; non-transfer cycles drive inst_w=00 (bubble) and in_w holds its value.
REQ-018 SHALL leave LOAD after exactly col transfers and enter GAP.
REQ-019 SHALL hold GAP for col cycles with inst_w=00, then enter EXEC, or enter DONE if the latched exec_len=0.
REQ-020 SHALL, in EXEC, drive inst_w=10 one cycle after each transfer; bubbles drive inst_w=00. EXEC ends after exec_len transfers and enters DRAIN.
REQ-021 SHALL increment out_cnt on each cycle with row_valid[col-1]=1 while busy, saturating at all-ones.
REQ-022 SHALL leave DRAIN when out_cnt equals the latched exec_len, entering DONE.
REQ-023 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL drive busy=1 in all states except IDLE.
REQ-025 SHALL hold mode at the latched cfg_mode throughout a job.
REQ-026 SHALL make a start in the DONE cycle ignored; the earliest new start is accepted the following cycle.

Reset
REQ-027 SHALL, on reset (including mid-job), return to IDLE next edge: in_w=0, inst_w=00, mode=0, data_ready=0, busy=0, done=0, out_cnt=0, all internal counters 0.
REQ-028 SHALL give reset priority over start.

Configuration
REQ-029 SHALL, with MAC_ROW_CTRL_PERF_EN defined, add output perf_cycles (16 bits): cleared on accepted start, incremented each busy cycle, saturating, held after done, reset to 0.
REQ-030 SHALL, without MAC_ROW_CTRL_PERF_EN, have no perf_cycles port and no associated logic.

Structure
REQ-031 SHALL place the state enum and the inst encodings INST_NOP=00, INST_LOAD=01 and INST_EXEC=10 in shared package mac_pkg.
REQ-032 SHALL be a single module with counters inline; no sub-module.

Verification
REQ-033 SHALL cover: col=8, start with exec_len=4 and data_valid held high -> 8 cycles inst_w=01, 8 cycles 00, 4 cycles 10; after 4 row_valid[7] pulses, done pulses once and out_cnt=4.
REQ-034 SHALL cover: data_valid toggling 1/0 during LOAD -> inst_w alternates 01/00, exactly 8 load cycles, in_w matches the accepted data sequence.
REQ-035 SHALL cover: exec_len=0 -> LOAD, GAP, then done; no inst_w=10 cycle; out_cnt=0.
REQ-036 SHALL cover: start asserted during EXEC -> ignored; latched exec_len unchanged; done pulses only once.
REQ-037 SHALL cover: reset asserted mid-EXEC -> next cycle inst_w=00, busy=0, out_cnt=0; a subsequent start runs a full job.
REQ-038 SHALL cover: with MAC_ROW_CTRL_PERF_EN, the scenario of REQ-033 -> perf_cycles equals the number of busy cycles from LOAD entry through DONE inclusive.
